// File: rtl/friscv_cdc_handshake_tx.sv
// Source end of a 4-phase req/ack CDC; req rises 1 cycle after accept, falls SYNC_DEPTH+1 after ack.
// in_ready is low while a handshake is in flight or a stale synchronised ack is still high.
module friscv_cdc_handshake_tx #(
  parameter int DATA_W     = 32,
  parameter int SYNC_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic              aclk,
  input  logic              srst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              cdc_req,
  output logic [DATA_W-1:0] cdc_data,
  input  logic              cdc_ack,
  output logic              busy,
  output logic [CNT_W-1:0]  xfer_cnt
);

  localparam int SD = (SYNC_DEPTH < 2) ? 2 : SYNC_DEPTH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    ACK_LOW = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SD-1:0]       r_ack_sync;
  logic                w_ack_s;
  logic                w_accept;
  logic                w_done;
  logic                r_req;
  logic [DATA_W-1:0]   r_data;
  logic [CNT_W-1:0]    r_cnt;

  always_ff @(posedge aclk) begin
    if (srst) begin
      r_ack_sync <= '0;
    end else begin
      r_ack_sync <= {r_ack_sync[SD-2:0], cdc_ack};
    end
  end

  assign w_ack_s  = r_ack_sync[SD-1];
  assign in_ready = (r_state == IDLE) & ~w_ack_s & ~srst;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid && in_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        if (w_ack_s) begin
          w_state_nxt = ACK_LOW;
        end
      end
      ACK_LOW: begin
        if (!w_ack_s) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // req is a plain flop output so the destination never sees a combinational glitch
  always_ff @(posedge aclk) begin
    if (srst) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= (w_state_nxt == REQ);
      if (w_accept) begin
        r_data <= in_data;
      end
      if (w_done) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign cdc_req  = r_req;
  assign cdc_data = r_data;
  assign busy     = (r_state != IDLE);
  assign xfer_cnt = r_cnt;

endmodule

// File: tb/tb_friscv_cdc_handshake_tx.sv
// Bench: instance A (SYNC_DEPTH=2, CNT_W=2) for directed cases, instance B (SYNC_DEPTH=3) randomised.
module tb_friscv_cdc_handshake_tx;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // instance A
  logic        a_srst, a_valid, a_ready, a_req, a_ack, a_busy, a_auto;
  logic [31:0] a_data, a_cdata;
  logic [1:0]  a_cnt;
  logic [31:0] qa[$];

  friscv_cdc_handshake_tx #(.DATA_W(32), .SYNC_DEPTH(2), .CNT_W(2)) u_dut_a (
    .aclk(aclk), .srst(a_srst), .in_valid(a_valid), .in_ready(a_ready), .in_data(a_data),
    .cdc_req(a_req), .cdc_data(a_cdata), .cdc_ack(a_ack), .busy(a_busy), .xfer_cnt(a_cnt)
  );

  // instance B
  logic        b_srst, b_valid, b_ready, b_req, b_ack, b_busy;
  logic [31:0] b_data, b_cdata;
  logic [15:0] b_cnt;
  logic [31:0] qb[$];

  friscv_cdc_handshake_tx #(.DATA_W(32), .SYNC_DEPTH(3), .CNT_W(16)) u_dut_b (
    .aclk(aclk), .srst(b_srst), .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data),
    .cdc_req(b_req), .cdc_data(b_cdata), .cdc_ack(b_ack), .busy(b_busy), .xfer_cnt(b_cnt)
  );

  // partner models: raise ack some cycles after req, drop it some cycles after req falls
  initial begin
    forever begin
      @(negedge aclk);
      if (a_auto) begin
        if (a_req && !a_ack) a_ack = 1'b1;
        else if (!a_req && a_ack) a_ack = 1'b0;
      end
    end
  end

  initial begin
    b_ack = 1'b0;
    forever begin
      @(negedge aclk);
      if (b_req && !b_ack) begin
        repeat ($urandom_range(0, 10)) @(negedge aclk);
        b_ack = 1'b1;
      end else if (!b_req && b_ack) begin
        repeat ($urandom_range(0, 10)) @(negedge aclk);
        b_ack = 1'b0;
      end
    end
  end

  // monitors: pop expected word on each req rise, model the counter on each completion
  logic        ma_req = 0, ma_busy = 0, ma_srst = 0;
  logic [31:0] ma_data = 0;
  int          ma_cnt = 0;
  logic        mb_req = 0, mb_busy = 0, mb_srst = 0;
  logic [31:0] mb_data = 0;
  int          mb_cnt = 0;
  int          mb_seen = 0;

  initial begin
    forever begin
      @(negedge aclk);
      if (ma_srst) begin
        ma_cnt = 0;
        qa.delete();
      end else begin
        if (a_busy) check("a_ready_while_busy", a_ready, 0);
        if (a_req && !ma_req) begin
          if (qa.size() == 0) check("a_unexpected_req", 1, 0);
          else check("a_word", a_cdata, qa.pop_front());
        end
        if (ma_busy && a_busy) check("a_data_stable", a_cdata, ma_data);
        if (ma_busy && !a_busy) begin
          ma_cnt = (ma_cnt + 1) % 4;
          check("a_xfer_cnt", a_cnt, ma_cnt);
        end
      end
      ma_req = a_req; ma_busy = a_busy; ma_data = a_cdata; ma_srst = a_srst;
    end
  end

  initial begin
    forever begin
      @(negedge aclk);
      if (mb_srst) begin
        mb_cnt = 0;
        qb.delete();
      end else begin
        if (b_busy) check("b_ready_while_busy", b_ready, 0);
        if (b_req && !mb_req) begin
          mb_seen++;
          if (qb.size() == 0) check("b_unexpected_req", 1, 0);
          else check("b_word", b_cdata, qb.pop_front());
        end
        if (mb_busy && b_busy) check("b_data_stable", b_cdata, mb_data);
        if (mb_busy && !b_busy) begin
          mb_cnt = (mb_cnt + 1) % 65536;
          check("b_xfer_cnt", b_cnt, mb_cnt);
        end
      end
      mb_req = b_req; mb_busy = b_busy; mb_data = b_cdata; mb_srst = b_srst;
    end
  end

  task automatic reset_a();
    a_srst = 1'b1;
    tick(); tick();
    a_srst = 1'b0;
    tick();
  endtask

  // in_valid is left as the caller set it; junk data is shown while waiting
  task automatic send_a(input logic [31:0] w);
    int n = 0;
    while (!a_ready && n < 300) begin
      a_data = $urandom;
      tick();
      n++;
    end
    if (!a_ready) check("a_ready_timeout", 0, 1);
    else begin
      a_data = w;
      qa.push_back(w);
      tick();
    end
  endtask

  task automatic wait_idle_a();
    int n = 0;
    while (a_busy && n < 500) begin
      tick();
      n++;
    end
    check("a_idle_timeout", a_busy, 0);
  endtask

  task automatic send_b(input logic [31:0] w);
    int n = 0;
    while (!b_ready && n < 300) begin
      b_valid = 1'($urandom_range(0, 1));
      b_data  = $urandom;
      tick();
      n++;
    end
    if (!b_ready) check("b_ready_timeout", 0, 1);
    else begin
      b_valid = 1'b1;
      b_data  = w;
      qb.push_back(w);
      tick();
    end
    b_valid = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    a_srst = 1'b1; a_valid = 1'b0; a_data = '0; a_ack = 1'b0; a_auto = 1'b0;
    b_srst = 1'b1; b_valid = 1'b0; b_data = '0;
    tick(); tick();
    check("rst_req", a_req, 0);
    check("rst_data", a_cdata, 0);
    check("rst_cnt", a_cnt, 0);
    check("rst_busy", a_busy, 0);
    check("rst_ready_in_reset", a_ready, 0);
    a_srst = 1'b0;
    tick();
    check("ready_after_rst", a_ready, 1);

    // basic transfer with a hand-driven partner
    a_valid = 1'b1; a_data = 32'hDEADBEEF; qa.push_back(32'hDEADBEEF);
    tick();
    check("basic_req_rise", a_req, 1);
    check("basic_ready_low", a_ready, 0);
    a_valid = 1'b0; a_data = 32'h0;
    tick();
    a_ack = 1'b1;
    tick(); tick();
    check("basic_req_hold", a_req, 1);
    tick();
    check("basic_req_fall", a_req, 0);
    check("basic_data_hold", a_cdata, 32'hDEADBEEF);
    check("basic_busy_acklow", a_busy, 1);
    tick();
    a_ack = 1'b0;
    tick(); tick();
    check("basic_still_busy", a_busy, 1);
    check("basic_cnt_pending", a_cnt, 0);
    tick();
    check("basic_idle", a_busy, 0);
    check("basic_cnt", a_cnt, 1);
    check("basic_ready_back", a_ready, 1);

    // back-pressure then wrap: counter runs 1,2,3,0,1
    reset_a();
    a_auto = 1'b1;
    a_valid = 1'b1;
    for (int k = 1; k <= 3; k++) send_a(32'(k));
    a_valid = 1'b0;
    wait_idle_a();
    check("bp_cnt3", a_cnt, 3);
    a_valid = 1'b1;
    send_a(32'd4);
    send_a(32'd5);
    a_valid = 1'b0;
    wait_idle_a();
    check("wrap_cnt", a_cnt, 1);

    // reset while waiting for ack
    a_auto = 1'b0;
    reset_a();
    a_valid = 1'b1;
    send_a(32'h77);
    a_valid = 1'b0;
    check("midreq_req_up", a_req, 1);
    a_srst = 1'b1;
    tick();
    check("midreq_req", a_req, 0);
    check("midreq_data", a_cdata, 0);
    check("midreq_busy", a_busy, 0);
    check("midreq_cnt", a_cnt, 0);
    a_srst = 1'b0;
    tick();

    // stale ack held across reset; valid raised once the synchroniser has seen it
    a_ack = 1'b1;
    a_srst = 1'b1;
    tick(); tick();
    a_srst = 1'b0;
    tick(); tick(); tick();
    a_valid = 1'b1; a_data = 32'h55;
    for (int k = 0; k < 3; k++) begin
      check("stale_ready", a_ready, 0);
      check("stale_req", a_req, 0);
      tick();
    end
    a_ack = 1'b0;
    tick();
    check("stale_ready_1cyc", a_ready, 0);
    tick();
    check("stale_ready_released", a_ready, 1);
    qa.push_back(32'h55);
    tick();
    check("stale_req_rise", a_req, 1);
    check("stale_data", a_cdata, 32'h55);
    a_valid = 1'b0;
    a_auto = 1'b1;
    wait_idle_a();
    check("stale_cnt", a_cnt, 1);

    // randomised traffic on the SYNC_DEPTH=3 instance
    b_srst = 1'b0;
    tick(); tick();
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      send_b($urandom);
    end
    begin
      int n = 0;
      while (b_busy && n < 500) begin
        tick();
        n++;
      end
      check("b_idle_timeout", b_busy, 0);
    end
    tick();
    check("b_final_cnt", b_cnt, 40);
    check("b_words_seen", mb_seen, 40);
    check("b_queue_empty", qb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
